// File: rtl/fp_divider.sv
// Sequential IEEE-754 divider: quotient = dividend / divisor.
// Restoring mantissa division producing one quotient bit per clock,
// truncating rounding, denormals flushed to zero on input and output.
//
// Handshake: start is sampled only while busy=0. The edge that accepts
// start raises busy. busy stays high until the edge that raises done.
// done is a one-cycle pulse, and quotient/div_by_zero hold until the next done.
// A start held during the done cycle is accepted on that cycle's edge.
module fp_divider #(
    parameter int EXP_W = 8,
    parameter int MNT_W = 23
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [EXP_W+MNT_W:0]       dividend,
    input  logic [EXP_W+MNT_W:0]       divisor,
    output logic                       busy,
    output logic                       done,
    output logic [EXP_W+MNT_W:0]       quotient,
    output logic                       div_by_zero,
    output logic [2:0]                 dbg_state
);

    localparam int W     = 1 + EXP_W + MNT_W;
    localparam int CNT_W = $clog2(MNT_W + 3);

    localparam logic [CNT_W-1:0]          CNT_LOAD = CNT_W'(MNT_W + 2);
    localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
    localparam logic signed [EXP_W+1:0]   BIAS_E   = (EXP_W+2)'(2**(EXP_W-1) - 1);
    localparam logic signed [EXP_W+1:0]   MAX_E    = (EXP_W+2)'(2**EXP_W - 1);
    localparam logic signed [EXP_W+1:0]   ZERO_E   = '0;
    localparam logic signed [EXP_W+1:0]   ONE_E    = (EXP_W+2)'(1);
    localparam logic [W-1:0]              QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MNT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_DIVIDE = 3'd2,
        S_NORM   = 3'd3,
        S_PACK   = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    logic [W-1:0]             r_a;
    logic [W-1:0]             r_b;
    logic                     r_sign;
    logic signed [EXP_W+1:0]  r_exp;
    logic [MNT_W:0]           r_mb;
    logic [MNT_W+1:0]         r_rem;
    logic [MNT_W+1:0]         r_q;
    logic [CNT_W-1:0]         r_cnt;
    logic [MNT_W-1:0]         r_mnt;
    logic                     r_special;
    logic [W-1:0]             r_special_q;
    logic                     r_special_dbz;

    // Operand fields
    logic                     w_sa, w_sb, w_sign;
    logic [EXP_W-1:0]         w_ea, w_eb;
    logic [MNT_W-1:0]         w_ma, w_mb;
    logic                     w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic signed [EXP_W+1:0]  w_exp_calc;

    // Special-case decode
    logic                     w_special;
    logic [W-1:0]             w_spec_q;
    logic                     w_spec_dbz;

    // Restoring step
    logic                     w_ge;
    logic [MNT_W+1:0]         w_sub;
    logic [MNT_W+1:0]         w_rem_next;
    logic [MNT_W+1:0]         w_q_next;

    // Final packing
    logic [W-1:0]             w_pack_q;

    assign dbg_state = r_state;

    assign w_sa = r_a[W-1];
    assign w_sb = r_b[W-1];
    assign w_ea = r_a[W-2:MNT_W];
    assign w_eb = r_b[W-2:MNT_W];
    assign w_ma = r_a[MNT_W-1:0];
    assign w_mb = r_b[MNT_W-1:0];
    assign w_sign = w_sa ^ w_sb;

    // Exponent field 0 covers both zero and denormals (flushed).
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (&w_ea) && (w_ma == '0);
    assign w_b_inf  = (&w_eb) && (w_mb == '0);
    assign w_a_nan  = (&w_ea) && (w_ma != '0);
    assign w_b_nan  = (&w_eb) && (w_mb != '0);

    assign w_exp_calc = signed'({2'b00, w_ea}) - signed'({2'b00, w_eb}) + BIAS_E;

    // Special-case priority: NaN-producing cases first, then infinities, then zeros.
    always_comb begin
        w_special  = 1'b1;
        w_spec_q   = '0;
        w_spec_dbz = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_q = QNAN;
        end else if (w_a_inf) begin
            w_spec_q = {w_sign, {EXP_W{1'b1}}, {MNT_W{1'b0}}};
        end else if (w_b_inf) begin
            w_spec_q = {w_sign, {(W-1){1'b0}}};
        end else if (w_b_zero) begin
            w_spec_q   = {w_sign, {EXP_W{1'b1}}, {MNT_W{1'b0}}};
            w_spec_dbz = 1'b1;
        end else if (w_a_zero) begin
            w_spec_q = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    // One restoring division step; the remainder stays below 2*mB so the shift cannot overflow.
    always_comb begin
        w_ge       = (r_rem >= {1'b0, r_mb});
        w_sub      = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
        w_rem_next = w_sub << 1;
        w_q_next   = {r_q[MNT_W:0], w_ge};
    end

    // Result assembly with overflow to Inf and underflow flush to zero.
    always_comb begin
        w_pack_q = {r_sign, r_exp[EXP_W-1:0], r_mnt};
        if (r_special) begin
            w_pack_q = r_special_q;
        end else if (r_exp >= MAX_E) begin
            w_pack_q = {r_sign, {EXP_W{1'b1}}, {MNT_W{1'b0}}};
        end else if (r_exp <= ZERO_E) begin
            w_pack_q = {r_sign, {(W-1){1'b0}}};
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_UNPACK;
            S_UNPACK: w_next_state = w_special ? S_PACK : S_DIVIDE;
            S_DIVIDE: if (r_cnt == CNT_ONE) w_next_state = S_NORM;
            S_NORM:   w_next_state = S_PACK;
            S_PACK:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Datapath and handshake registers, sequenced by the current state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a           <= '0;
            r_b           <= '0;
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_mb          <= '0;
            r_rem         <= '0;
            r_q           <= '0;
            r_cnt         <= '0;
            r_mnt         <= '0;
            r_special     <= 1'b0;
            r_special_q   <= '0;
            r_special_dbz <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            quotient      <= '0;
            div_by_zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a  <= dividend;
                        r_b  <= divisor;
                        busy <= 1'b1;
                    end
                end
                S_UNPACK: begin
                    r_sign        <= w_sign;
                    r_exp         <= w_exp_calc;
                    r_mb          <= {1'b1, w_mb};
                    r_rem         <= {2'b01, w_ma};
                    r_q           <= '0;
                    r_cnt         <= CNT_LOAD;
                    r_special     <= w_special;
                    r_special_q   <= w_spec_q;
                    r_special_dbz <= w_spec_dbz;
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CNT_ONE;
                end
                S_NORM: begin
                    // Ratio of two [1,2) mantissas lies in (0.5,2): at most one shift.
                    if (r_q[MNT_W+1]) begin
                        r_mnt <= r_q[MNT_W:1];
                    end else begin
                        r_mnt <= r_q[MNT_W-1:0];
                        r_exp <= r_exp - ONE_E;
                    end
                end
                S_PACK: begin
                    quotient    <= w_pack_q;
                    div_by_zero <= r_special && r_special_dbz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: vector table, power-of-two random cases,
// and hand-written sequences for ignored start, back-to-back and mid-op reset.
module tb_fp_divider;

  localparam int W = 32;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic          div_by_zero;
  logic [2:0]    dbg_state;

  fp_divider #(.EXP_W(8), .MNT_W(23)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: {quotient, div_by_zero}
  logic [W:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // monitor: compare every done against the oldest expected result
  always @(negedge clock) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("quotient", 64'(quotient), 64'(e[W:1]));
        check("div_by_zero", 64'(div_by_zero), 64'(e[0]));
      end
    end
  end

  // drivers
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic dbz);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back({q, dbz});
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  // counts edges until done is seen; called #1 after the accepting edge
  task automatic wait_done(input int exp_edges, input string name);
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(name, 64'(n), 64'(exp_edges));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28}; // 6/2
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 28}; // 1/3
    vecs[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 2};  // -1/0
    vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 2};  // 0/0
    vecs[4]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 28}; // overflow
    vecs[5]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 28}; // underflow
    vecs[6]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 2};  // Inf/2
    vecs[7]  = '{32'h40400000, 32'hFF800000, 32'h80000000, 1'b0, 2};  // 3/-Inf
    vecs[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 2};  // NaN/1
    vecs[9]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 2};  // Inf/Inf
    vecs[10] = '{32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 2};  // -0/5
    vecs[11] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 28}; // -6/2
    vecs[12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 28}; // 1/1
    vecs[13] = '{32'h3FC00000, 32'hBF800000, 32'hBFC00000, 1'b0, 28}; // 1.5/-1
    vecs[14] = '{32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 2};  // denormal/1
    vecs[15] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAA, 1'b0, 28}; // 2/3

    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_quotient", 64'(quotient), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // table-driven vectors (issued back-to-back: each start lands in the previous done cycle)
    for (int i = 0; i < 16; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz);
      wait_done(vecs[i].lat, "latency");
    end

    // random power-of-two divisors: exact result is the dividend mantissa with shifted exponent
    for (int i = 0; i < 8; i++) begin
      int ea, eb, m, sa, sb;
      logic [W-1:0] a, b, q;
      ea = $urandom_range(100, 150);
      eb = $urandom_range(100, 150);
      m  = $urandom_range(0, 32'h7FFFFF);
      sa = $urandom_range(0, 1);
      sb = $urandom_range(0, 1);
      a = {1'(sa), 8'(ea), 23'(m)};
      b = {1'(sb), 8'(eb), 23'd0};
      q = {1'(sa ^ sb), 8'(ea - eb + 127), 23'(m)};
      start_op(a, b, q, 1'b0);
      wait_done(28, "latency_rand");
    end

    // ignored start at cycle 10 of a division
    @(posedge clock);
    #1;
    start_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    start    = 1'b1;
    dividend = 32'h3F800000;
    divisor  = 32'h40400000;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_ignored_start", 64'(busy), 64'd1);
    check("state_ignored_start", 64'(dbg_state), 64'd2);
    wait_done(18, "latency_ignored");
    repeat (40) begin
      @(posedge clock);
      #1;
    end
    check("idle_after_ignored", 64'(busy), 64'd0);
    check("queue_empty_ignored", 64'(exp_q.size()), 64'd0);

    // back-to-back: start held during the done cycle
    start_op(32'h41200000, 32'h40A00000, 32'h40000000, 1'b0);
    wait_done(28, "latency_b2b_first");
    check("done_pulse_b2b", 64'(done), 64'd1);
    start    = 1'b1;
    dividend = 32'h3F800000;
    divisor  = 32'h00000000;
    exp_q.push_back({32'h7F800000, 1'b1});
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_b2b", 64'(busy), 64'd1);
    check("done_low_b2b", 64'(done), 64'd0);
    wait_done(2, "latency_b2b_second");

    // reset at cycle 15 of a division (quotient/dbz currently nonzero)
    @(posedge clock);
    #1;
    start_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    repeat (14) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_dbz", 64'(div_by_zero), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (done) check("no_done_after_abort", 64'd1, 64'd0);
    end
    check("state_after_abort", 64'(dbg_state), 64'd0);
    start_op(32'h41200000, 32'h40A00000, 32'h40000000, 1'b0);
    wait_done(28, "latency_after_reset");

    repeat (4) @(posedge clock);
    #1;
    check("queue_empty_end", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
